// File: rtl/lc3b_types.sv
// Shared LC-3b memory-side types: word/line typedefs, line offset width and
// the pmem responder state encoding.
package lc3b_types;

  localparam int L2_LINE_BITS   = 256;
  localparam int L2_OFFSET_BITS = $clog2(L2_LINE_BITS / 8);

  typedef logic [15:0]             lc3b_word;
  typedef logic [L2_LINE_BITS-1:0] lc3b_l2_line;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    RESP = 2'd2
  } pmem_state_t;

  // Debug counters stick at all-ones instead of wrapping to zero.
  function automatic logic [15:0] sat_inc16(input logic [15:0] value);
    return (value == 16'hFFFF) ? value : value + 16'd1;
  endfunction

endpackage

// File: rtl/pmem_line_array.sv
// Single-port line storage: synchronous write, registered read. The read
// register doubles as the responder's rdata output and so is reset.
module pmem_line_array #(
  parameter int LINE_BITS  = 256,
  parameter int INDEX_BITS = 11
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  we,
  input  logic                  re,
  input  logic [INDEX_BITS-1:0] idx,
  input  logic [LINE_BITS-1:0]  wdata,
  output logic [LINE_BITS-1:0]  rdata
);

  logic [LINE_BITS-1:0] mem [2**INDEX_BITS];

  // NOTE: the storage array has no reset so it can map onto a RAM macro;
  // only the output register is reset.
  always_ff @(posedge clk) begin
    if (we) mem[idx] <= wdata;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)  rdata <= '0;
    else if (re) rdata <= mem[idx];
  end

endmodule

// File: rtl/pmem_line_responder.sv
// Physical-memory responder: accepts whole-line reads/writes and answers with
// a one-cycle pmem_resp after a fixed, per-op programmable latency.
module pmem_line_responder
  import lc3b_types::*;
#(
  parameter int LINE_BITS     = 256,
  parameter int INDEX_BITS    = 11,
  parameter int READ_LATENCY  = 8,
  parameter int WRITE_LATENCY = 6
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 pmem_read,
  input  logic                 pmem_write,
  input  lc3b_word             pmem_address,
  input  logic [LINE_BITS-1:0] pmem_wdata,
  output logic                 pmem_resp,
  output logic [LINE_BITS-1:0] pmem_rdata,
  output logic                 proto_err,
  output logic [15:0]          rd_count,
  output logic [15:0]          wr_count
);

  localparam int OFF = $clog2(LINE_BITS / 8);

  pmem_state_t           state, next_state;
  logic [15:0]           cnt, next_cnt;
  logic [INDEX_BITS-1:0] req_idx, idx_q, arr_idx;
  logic                  op_write;
  logic                  accept, cur_write, arr_we, arr_re;
  logic                  unused_addr;

  assign req_idx     = pmem_address[OFF+INDEX_BITS-1:OFF];
  assign unused_addr = ^pmem_address;

  // Write wins when both request lines are high.
  assign accept    = (state == IDLE) && (pmem_read || pmem_write);
  assign cur_write = (state == IDLE) ? pmem_write : op_write;

  // Writes commit on the acceptance edge from the live inputs; reads look up
  // the latched index on the edge that enters RESP.
  assign arr_we  = accept && pmem_write;
  assign arr_re  = (state != RESP) && (next_state == RESP) && !cur_write;
  assign arr_idx = (state == IDLE) ? req_idx : idx_q;

  assign pmem_resp = (state == RESP);

  // NOTE: every signal written here gets a default first so no latch is inferred.
  always_comb begin
    next_state = state;
    next_cnt   = cnt;
    case (state)
      IDLE: begin
        if (pmem_write) begin
          next_cnt   = 16'(WRITE_LATENCY - 1);
          next_state = (WRITE_LATENCY > 1) ? BUSY : RESP;
        end else if (pmem_read) begin
          next_cnt   = 16'(READ_LATENCY - 1);
          next_state = (READ_LATENCY > 1) ? BUSY : RESP;
        end
      end
      BUSY: begin
        if (cnt == '0) next_state = RESP;
        else           next_cnt   = cnt - 16'd1;
      end
      RESP:    next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      idx_q     <= '0;
      op_write  <= 1'b0;
      proto_err <= 1'b0;
      rd_count  <= '0;
      wr_count  <= '0;
    end else begin
      state <= next_state;
      cnt   <= next_cnt;
      if (accept) begin
        idx_q    <= req_idx;
        op_write <= pmem_write;
        if (pmem_read && pmem_write) proto_err <= 1'b1;
      end
      if (state == RESP) begin
        if (op_write) wr_count <= sat_inc16(wr_count);
        else          rd_count <= sat_inc16(rd_count);
      end
    end
  end

  pmem_line_array #(
    .LINE_BITS  (LINE_BITS),
    .INDEX_BITS (INDEX_BITS)
  ) u_array (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (arr_we),
    .re    (arr_re),
    .idx   (arr_idx),
    .wdata (pmem_wdata),
    .rdata (pmem_rdata)
  );

endmodule

// File: tb/tb_pmem_line_responder.sv
// Directed bench for pmem_line_responder: a vector table of whole-line
// transactions plus hand-written reset, aliasing, protocol and saturation cases.
module tb_pmem_line_responder;

  localparam int LB = 256;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          pmem_read = 1'b0;
  logic          pmem_write = 1'b0;
  logic [15:0]   pmem_address = '0;
  logic [LB-1:0] pmem_wdata = '0;
  logic          pmem_resp;
  logic [LB-1:0] pmem_rdata;
  logic          proto_err;
  logic [15:0]   rd_count, wr_count;

  // Second instance shares the request side but stores only 6 index bits.
  logic          d6_resp;
  logic [LB-1:0] d6_rdata;
  logic          d6_proto_err;
  logic [15:0]   d6_rd_count, d6_wr_count;

  pmem_line_responder dut (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(pmem_resp),
    .pmem_rdata(pmem_rdata), .proto_err(proto_err), .rd_count(rd_count),
    .wr_count(wr_count)
  );

  pmem_line_responder #(.INDEX_BITS(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .pmem_read(pmem_read), .pmem_write(pmem_write),
    .pmem_address(pmem_address), .pmem_wdata(pmem_wdata), .pmem_resp(d6_resp),
    .pmem_rdata(d6_rdata), .proto_err(d6_proto_err), .rd_count(d6_rd_count),
    .wr_count(d6_wr_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          rd;
    logic          wr;
    logic [15:0]   addr;
    logic [LB-1:0] wdata;
    logic [LB-1:0] exp_rdata;
    int            exp_lat;
  } vec_t;

  localparam logic [LB-1:0] LA5 = {32{8'hA5}};
  localparam logic [LB-1:0] L5A = {32{8'h5A}};
  localparam logic [LB-1:0] L02 = {16{16'h0200}};
  localparam logic [LB-1:0] L03 = {16{16'h0300}};
  localparam logic [LB-1:0] L11 = {16{16'h1111}};
  localparam logic [LB-1:0] L22 = {16{16'h2222}};
  localparam logic [LB-1:0] L3C = {32{8'h3C}};
  localparam logic [LB-1:0] LC3 = {32{8'hC3}};

  vec_t vecs[8];
  int   n_vec  = 0;
  int   n_miss = 0;

  task automatic check(input string name, input logic [LB-1:0] actual,
                       input logic [LB-1:0] expected);
    n_vec++;
    if (actual !== expected) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, actual, expected);
    end
  endtask

  // Issues one request, counts negedges after the acceptance edge until resp,
  // and drops the request on resp. disturb scrambles every input while BUSY.
  task automatic run_txn(input logic rd, input logic wr, input logic [15:0] addr,
                         input logic [LB-1:0] wdata, input logic disturb,
                         output int lat, output logic [LB-1:0] rdata,
                         output logic [LB-1:0] rdata6);
    lat    = -1;
    rdata  = '0;
    rdata6 = '0;
    @(negedge clk);
    pmem_read    = rd;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wdata;
    @(posedge clk);
    for (int n = 1; n <= 40; n++) begin
      @(negedge clk);
      if (disturb && n == 1) begin
        pmem_address = addr + 16'h0100;
        pmem_wdata   = ~wdata;
        pmem_read    = 1'b0;
        pmem_write   = 1'b0;
      end
      if (pmem_resp) begin
        lat    = n;
        rdata  = pmem_rdata;
        rdata6 = d6_rdata;
        break;
      end
    end
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
  endtask

  // Starts a request and asserts reset at negedge number busy_cycle after
  // acceptance, then confirms no resp ever appears after release.
  task automatic reset_mid(input logic wr, input logic [15:0] addr,
                           input logic [LB-1:0] wdata, input int busy_cycle,
                           input string tag);
    logic seen;
    seen = 1'b0;
    @(negedge clk);
    pmem_read    = !wr;
    pmem_write   = wr;
    pmem_address = addr;
    pmem_wdata   = wdata;
    @(posedge clk);
    repeat (busy_cycle) @(negedge clk);
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    rst_n      = 1'b0;
    #1;
    check({tag, "_resp_in_reset"}, LB'(pmem_resp), '0);
    check({tag, "_rdata_in_reset"}, pmem_rdata, '0);
    check({tag, "_proto_in_reset"}, LB'(proto_err), '0);
    check({tag, "_counts_in_reset"}, LB'({rd_count, wr_count}), '0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    for (int n = 0; n < 15; n++) begin
      @(negedge clk);
      if (pmem_resp) seen = 1'b1;
    end
    check({tag, "_no_resp_after_reset"}, LB'(seen), '0);
  endtask

  int            lat;
  logic [LB-1:0] rdata, rdata6;

  initial begin
    vecs[0] = '{1'b0, 1'b1, 16'h0040, LA5, '0,  7};
    vecs[1] = '{1'b1, 1'b0, 16'h0040, '0,  LA5, 9};
    vecs[2] = '{1'b1, 1'b0, 16'h005F, '0,  LA5, 9};
    vecs[3] = '{1'b0, 1'b1, 16'h0060, L5A, LA5, 7};
    vecs[4] = '{1'b1, 1'b0, 16'h0060, '0,  L5A, 9};
    vecs[5] = '{1'b1, 1'b0, 16'h0040, '0,  LA5, 9};
    vecs[6] = '{1'b0, 1'b1, 16'h0200, L02, LA5, 7};
    vecs[7] = '{1'b0, 1'b1, 16'h0300, L03, LA5, 7};

    repeat (3) @(negedge clk);
    check("reset_resp", LB'(pmem_resp), '0);
    check("reset_rdata", pmem_rdata, '0);
    check("reset_proto_err", LB'(proto_err), '0);
    check("reset_counts", LB'({rd_count, wr_count}), '0);
    rst_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 8; i++) begin
      run_txn(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wdata, 1'b0,
              lat, rdata, rdata6);
      check($sformatf("vec%0d_latency", i), LB'(lat), LB'(vecs[i].exp_lat));
      check($sformatf("vec%0d_rdata", i), rdata, vecs[i].exp_rdata);
      if (i == 1) begin
        @(negedge clk);
        check("first_pair_counts", LB'({rd_count, wr_count}), LB'({16'd1, 16'd1}));
      end
    end
    @(negedge clk);
    check("table_counts", LB'({rd_count, wr_count}), LB'({16'd4, 16'd4}));

    // Aliasing: 0x0800 folds onto line 0 only in the 6-index-bit instance.
    run_txn(1'b0, 1'b1, 16'h0000, L11, 1'b0, lat, rdata, rdata6);
    run_txn(1'b0, 1'b1, 16'h0800, L22, 1'b0, lat, rdata, rdata6);
    run_txn(1'b1, 1'b0, 16'h0000, '0, 1'b0, lat, rdata, rdata6);
    check("alias_full_index", rdata, L11);
    check("alias_6bit_index", rdata6, L22);

    // Inputs scrambled and request dropped while BUSY: latched values win.
    run_txn(1'b1, 1'b0, 16'h0200, '0, 1'b1, lat, rdata, rdata6);
    check("disturb_latency", LB'(lat), LB'(9));
    check("disturb_rdata", rdata, L02);
    @(negedge clk);
    check("pre_proto_counts", LB'({rd_count, wr_count}), LB'({16'd6, 16'd6}));
    check("pre_proto_err", LB'(proto_err), '0);

    // Read and write together: write wins, error flag is sticky.
    run_txn(1'b1, 1'b1, 16'h0100, L3C, 1'b0, lat, rdata, rdata6);
    check("proto_latency", LB'(lat), LB'(7));
    check("proto_rdata_holds", rdata, L02);
    @(negedge clk);
    check("proto_err_set", LB'(proto_err), LB'(1));
    check("proto_counts", LB'({rd_count, wr_count}), LB'({16'd6, 16'd7}));
    run_txn(1'b1, 1'b0, 16'h0100, '0, 1'b0, lat, rdata, rdata6);
    check("proto_readback", rdata, L3C);
    @(negedge clk);
    check("proto_err_sticky", LB'(proto_err), LB'(1));

    reset_mid(1'b0, 16'h0100, '0, 3, "rst_read");
    run_txn(1'b1, 1'b0, 16'h0100, '0, 1'b0, lat, rdata, rdata6);
    check("post_reset_latency", LB'(lat), LB'(9));
    check("post_reset_rdata", rdata, L3C);

    reset_mid(1'b1, 16'h0400, LC3, 2, "rst_write");
    run_txn(1'b1, 1'b0, 16'h0400, '0, 1'b0, lat, rdata, rdata6);
    check("committed_write_kept", rdata, LC3);
    @(negedge clk);
    check("post_reset_counts", LB'({rd_count, wr_count}), LB'({16'd1, 16'd0}));

    // Saturation from a forced preload.
    force dut.rd_count = 16'hFFFE;
    @(negedge clk);
    release dut.rd_count;
    run_txn(1'b1, 1'b0, 16'h0040, '0, 1'b0, lat, rdata, rdata6);
    @(negedge clk);
    check("sat_first", LB'(rd_count), LB'(16'hFFFF));
    run_txn(1'b1, 1'b0, 16'h0040, '0, 1'b0, lat, rdata, rdata6);
    @(negedge clk);
    check("sat_second", LB'(rd_count), LB'(16'hFFFF));
    check("sat_wr_untouched", LB'(wr_count), LB'(16'd0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
